// File: rtl/dem_gpg_ctrl.sv
// Stopwatch/clock control FSM: debounced buttons -> count tick, field select, set-step strobes, clear, blink.
// Latency: a press seen at an edge drives the registered outputs from that edge on. No backpressure; strobes are fire-and-forget.
module dem_gpg_ctrl #(
    parameter int unsigned DIV_100HZ = 500000,
    parameter int unsigned HOLD_CYC  = 25000000,
    parameter int unsigned REP_CYC   = 10000000,
    parameter int unsigned BLINK_CYC = 12500000
) (
    input  logic       ckht,
    input  logic       rst,
    input  logic       btn_ss,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_dw,
    input  logic       btn_clr,
    output logic       ena_db,
    output logic [1:0] gt_mod,
    output logic       ena_up,
    output logic       ena_dw,
    output logic       ena5hz,
    output logic       clr_cnt,
    output logic       running,
    output logic       blink
);

    typedef enum logic [2:0] {ST_STOP, ST_RUN, ST_SET_S, ST_SET_M, ST_SET_H} state_t;

    localparam int PW = (DIV_100HZ > 1) ? $clog2(DIV_100HZ) : 1;
    localparam int RW = $clog2(HOLD_CYC + 1);
    localparam int BW = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;
    localparam logic [PW-1:0] PRE_TOP    = PW'(DIV_100HZ - 1);
    localparam logic [RW-1:0] HOLD_V     = RW'(HOLD_CYC);
    localparam logic [RW-1:0] REP_RELOAD = RW'(HOLD_CYC - REP_CYC + 1);
    localparam logic [BW-1:0] BLINK_TOP  = BW'(BLINK_CYC - 1);

    state_t        state_q, state_d;
    logic [4:0]    btn_q;
    logic [4:0]    btn_now;
    logic [4:0]    press;
    logic          armed_q;
    logic [PW-1:0] pre_q, pre_d;
    logic [RW-1:0] rcnt_q, rcnt_d;
    logic          act_q, act_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic          ena_db_q, ena_db_d;
    logic [1:0]    gt_mod_q, gt_mod_d;
    logic          ena_up_q, ena_up_d;
    logic          ena_dw_q, ena_dw_d;
    logic          ena5hz_q, ena5hz_d;
    logic          clr_q, clr_d;
    logic          running_q, running_d;
    logic          blink_q, blink_d;
    logic          in_set_d;
    logic          stay;
    logic          one_held;

    // armed_q masks the first edge after reset so buttons held through reset are not seen as presses
    assign btn_now = {btn_clr, btn_dw, btn_up, btn_mode, btn_ss};
    assign press   = btn_now & ~btn_q & {5{armed_q}};

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_STOP:  if (press[0]) state_d = ST_RUN;
                      else if (press[1]) state_d = ST_SET_S;
            ST_RUN:   if (press[0]) state_d = ST_STOP;
            ST_SET_S: if (press[1]) state_d = ST_SET_M;
            ST_SET_M: if (press[1]) state_d = ST_SET_H;
            ST_SET_H: if (press[1]) state_d = ST_STOP;
            default:  state_d = ST_STOP;
        endcase
    end

    always_comb begin
        in_set_d  = (state_d == ST_SET_S) || (state_d == ST_SET_M) || (state_d == ST_SET_H);
        stay      = (state_d == state_q);
        one_held  = btn_up ^ btn_dw;
        running_d = (state_d == ST_RUN);
        case (state_d)
            ST_SET_S: gt_mod_d = 2'b01;
            ST_SET_M: gt_mod_d = 2'b10;
            ST_SET_H: gt_mod_d = 2'b11;
            default:  gt_mod_d = 2'b00;
        endcase
        ena_up_d = in_set_d & btn_up & ~btn_dw;
        ena_dw_d = in_set_d & btn_dw & ~btn_up;
        clr_d    = (state_q == ST_STOP) & press[4];

        pre_d    = pre_q;
        ena_db_d = 1'b0;
        if (clr_d) begin
            pre_d = '0;
        end else if (running_d) begin
            if (pre_q == PRE_TOP) begin
                pre_d    = '0;
                ena_db_d = 1'b1;
            end else begin
                pre_d = pre_q + PW'(1);
            end
        end

        // Repeat counter reloads so the next match lands REP_CYC cycles later
        act_d    = 1'b0;
        rcnt_d   = '0;
        ena5hz_d = 1'b0;
        if (in_set_d && stay && one_held) begin
            if (press[2] || press[3]) begin
                act_d    = 1'b1;
                rcnt_d   = RW'(1);
                ena5hz_d = 1'b1;
            end else if (act_q) begin
                act_d = 1'b1;
                if (rcnt_q == HOLD_V) begin
                    ena5hz_d = 1'b1;
                    rcnt_d   = REP_RELOAD;
                end else begin
                    rcnt_d = rcnt_q + RW'(1);
                end
            end
        end

        blink_d = 1'b1;
        bcnt_d  = '0;
        if (in_set_d && stay && !act_d) begin
            if (bcnt_q == BLINK_TOP) begin
                blink_d = ~blink_q;
            end else begin
                blink_d = blink_q;
                bcnt_d  = bcnt_q + BW'(1);
            end
        end
    end

    always_ff @(posedge ckht) begin
        if (rst) begin
            state_q   <= ST_STOP;
            btn_q     <= '0;
            armed_q   <= 1'b0;
            pre_q     <= '0;
            rcnt_q    <= '0;
            act_q     <= 1'b0;
            bcnt_q    <= '0;
            ena_db_q  <= 1'b0;
            gt_mod_q  <= 2'b00;
            ena_up_q  <= 1'b0;
            ena_dw_q  <= 1'b0;
            ena5hz_q  <= 1'b0;
            clr_q     <= 1'b0;
            running_q <= 1'b0;
            blink_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            btn_q     <= btn_now;
            armed_q   <= 1'b1;
            pre_q     <= pre_d;
            rcnt_q    <= rcnt_d;
            act_q     <= act_d;
            bcnt_q    <= bcnt_d;
            ena_db_q  <= ena_db_d;
            gt_mod_q  <= gt_mod_d;
            ena_up_q  <= ena_up_d;
            ena_dw_q  <= ena_dw_d;
            ena5hz_q  <= ena5hz_d;
            clr_q     <= clr_d;
            running_q <= running_d;
            blink_q   <= blink_d;
        end
    end

    assign ena_db  = ena_db_q;
    assign gt_mod  = gt_mod_q;
    assign ena_up  = ena_up_q;
    assign ena_dw  = ena_dw_q;
    assign ena5hz  = ena5hz_q;
    assign clr_cnt = clr_q;
    assign running = running_q;
    assign blink   = blink_q;

endmodule

// File: tb/tb_dem_gpg_ctrl.sv
// Bench for dem_gpg_ctrl: directed scenarios plus random button activity against a behavioural model.
module tb_dem_gpg_ctrl;

    localparam int DIV  = 4;
    localparam int HOLD = 10;
    localparam int REP  = 3;
    localparam int BLK  = 5;

    logic       ckht = 1'b0;
    logic       rst  = 1'b1;
    logic       b_ss = 1'b0, b_mode = 1'b0, b_up = 1'b0, b_dw = 1'b0, b_clr = 1'b0;
    logic       ena_db, ena_up, ena_dw, ena5hz, clr_cnt, running, blink;
    logic [1:0] gt_mod;

    dem_gpg_ctrl #(
        .DIV_100HZ(DIV), .HOLD_CYC(HOLD), .REP_CYC(REP), .BLINK_CYC(BLK)
    ) dut (
        .ckht(ckht), .rst(rst),
        .btn_ss(b_ss), .btn_mode(b_mode), .btn_up(b_up), .btn_dw(b_dw), .btn_clr(b_clr),
        .ena_db(ena_db), .gt_mod(gt_mod), .ena_up(ena_up), .ena_dw(ena_dw),
        .ena5hz(ena5hz), .clr_cnt(clr_cnt), .running(running), .blink(blink)
    );

    always #5 ckht = ~ckht;

    int errs   = 0;
    int checks = 0;

    // Model: state 0=STOP 1=RUN 2..4=SET seconds/minutes/hours
    int         m_st = 0;
    int         run_cnt = 0;
    int         held = -1;
    int         bph = 0;
    logic [4:0] m_prev = 5'b0;
    bit         m_armed = 1'b0;
    bit         e_db = 0, e_up = 0, e_dw = 0, e_step = 0, e_clr = 0, e_run = 0, e_blink = 1;
    logic [1:0] e_gt = 2'b00;

    int db_cnt = 0, step_cnt = 0, clr_seen = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        logic [4:0] lv, pr;
        int  nst;
        bit  in_set, stay, one;
        lv = {b_clr, b_dw, b_up, b_mode, b_ss};
        if (rst) begin
            m_st = 0; m_prev = 5'b0; m_armed = 1'b0; run_cnt = 0; held = -1; bph = 0;
            e_db = 0; e_gt = 2'b00; e_up = 0; e_dw = 0; e_step = 0; e_clr = 0; e_run = 0; e_blink = 1;
            return;
        end
        pr = m_armed ? (lv & ~m_prev) : 5'b0;
        m_prev  = lv;
        m_armed = 1'b1;

        nst = m_st;
        if (m_st == 0) begin
            if (pr[0]) nst = 1;
            else if (pr[1]) nst = 2;
        end else if (m_st == 1) begin
            if (pr[0]) nst = 0;
        end else if (pr[1]) begin
            nst = (m_st == 4) ? 0 : m_st + 1;
        end

        in_set = (nst >= 2);
        stay   = (nst == m_st);
        one    = (b_up != b_dw);
        e_run  = (nst == 1);
        e_gt   = in_set ? 2'(nst - 1) : 2'b00;
        e_up   = in_set && b_up && !b_dw;
        e_dw   = in_set && b_dw && !b_up;
        e_clr  = (m_st == 0) && pr[4];

        e_db = 0;
        if (e_clr) run_cnt = 0;
        else if (nst == 1) begin
            run_cnt++;
            e_db = (run_cnt % DIV == 0);
        end

        e_step = 0;
        if (in_set && stay && one) begin
            if (pr[2] || pr[3]) begin
                held = 0;
                e_step = 1;
            end else if (held >= 0) begin
                held++;
                e_step = (held >= HOLD) && ((held - HOLD) % REP == 0);
            end
        end else begin
            held = -1;
        end

        if (!(in_set && stay && held < 0)) begin
            bph = 0;
            e_blink = 1;
        end else begin
            bph++;
            e_blink = ((bph / BLK) % 2) == 0;
        end
        m_st = nst;
    endtask

    task automatic tick();
        @(posedge ckht);
        model_edge();
        #1;
        chk("ena_db",  32'(ena_db),  32'(e_db));
        chk("gt_mod",  32'(gt_mod),  32'(e_gt));
        chk("ena_up",  32'(ena_up),  32'(e_up));
        chk("ena_dw",  32'(ena_dw),  32'(e_dw));
        chk("ena5hz",  32'(ena5hz),  32'(e_step));
        chk("clr_cnt", 32'(clr_cnt), 32'(e_clr));
        chk("running", 32'(running), 32'(e_run));
        chk("blink",   32'(blink),   32'(e_blink));
        if (ena_db)  db_cnt++;
        if (ena5hz)  step_cnt++;
        if (clr_cnt) clr_seen++;
    endtask

    // which: 0 ss, 1 mode, 4 clr
    task automatic press(input int which);
        if (which == 0) b_ss = 1'b1;
        else if (which == 1) b_mode = 1'b1;
        else b_clr = 1'b1;
        tick();
        b_ss = 1'b0; b_mode = 1'b0; b_clr = 1'b0;
        tick();
    endtask

    initial begin
        logic [31:0] mask;
        mask = 32'h0;

        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_gt_mod",  32'(gt_mod),  32'd0);
        chk("rst_blink",   32'(blink),   32'd1);
        chk("rst_running", 32'(running), 32'd0);
        chk("rst_ena5hz",  32'(ena5hz),  32'd0);
        tick();

        // start, 12 cycles of RUN, stop
        db_cnt = 0;
        press(0);
        chk("run_level", 32'(running), 32'd1);
        repeat (10) tick();
        press(0);
        chk("db_pulses", 32'(db_cnt), 32'd3);
        chk("stopped", 32'(running), 32'd0);
        // leave the prescaler at phase 2, then resume
        press(0);
        b_ss = 1'b1; tick(); b_ss = 1'b0; tick();
        repeat (3) tick();
        b_ss = 1'b1; tick();
        chk("resume_first", 32'(ena_db), 32'd0);
        b_ss = 1'b0; tick();
        chk("resume_tick", 32'(ena_db), 32'd1);
        press(0);

        // mode cycle
        press(1); chk("mode_s", 32'(gt_mod), 32'd1);
        repeat (7) tick();
        press(1); chk("mode_m", 32'(gt_mod), 32'd2);
        press(1); chk("mode_h", 32'(gt_mod), 32'd3);
        press(1); chk("mode_stop", 32'(gt_mod), 32'd0);
        press(0);
        press(1); chk("mode_in_run", 32'(gt_mod), 32'd0);
        chk("mode_in_run_running", 32'(running), 32'd1);
        press(0);

        // hold up in SET_M
        press(1); press(1);
        b_up = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (ena5hz) mask[i] = 1'b1;
            chk("hold_up_level", 32'(ena_up), 32'd1);
        end
        chk("hold_pulse_mask", mask, 32'h0012_4802);
        b_up = 1'b0;
        step_cnt = 0;
        repeat (12) tick();
        chk("after_release", 32'(step_cnt), 32'd0);

        // both held, then dw released
        step_cnt = 0;
        b_up = 1'b1; b_dw = 1'b1;
        repeat (8) tick();
        b_dw = 1'b0;
        repeat (15) tick();
        chk("both_then_one", 32'(step_cnt), 32'd0);
        b_up = 1'b0; tick();
        b_up = 1'b1; tick();
        chk("repress_step", 32'(ena5hz), 32'd1);
        b_up = 1'b0; tick();

        // clear in STOP and in RUN
        press(1); press(1);
        clr_seen = 0;
        b_clr = 1'b1; tick();
        chk("clr_pulse", 32'(clr_cnt), 32'd1);
        b_clr = 1'b0; tick();
        chk("clr_single", 32'(clr_cnt), 32'd0);
        press(0);
        b_clr = 1'b1; tick(); b_clr = 1'b0; tick();
        press(0);
        chk("clr_count", 32'(clr_seen), 32'd1);

        // reset in SET_H with up held
        press(1); press(1); press(1);
        chk("seth", 32'(gt_mod), 32'd3);
        b_up = 1'b1;
        repeat (5) tick();
        rst = 1'b1; tick();
        chk("rst_mid_gt", 32'(gt_mod), 32'd0);
        chk("rst_mid_step", 32'(ena5hz), 32'd0);
        rst = 1'b0;
        step_cnt = 0;
        repeat (15) tick();
        chk("rst_no_step", 32'(step_cnt), 32'd0);
        b_up = 1'b0; tick();

        // random activity
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 11) == 0) b_ss   = ~b_ss;
            if ($urandom_range(0, 9)  == 0) b_mode = ~b_mode;
            if ($urandom_range(0, 15) == 0) b_up   = ~b_up;
            if ($urandom_range(0, 15) == 0) b_dw   = ~b_dw;
            if ($urandom_range(0, 7)  == 0) b_clr  = ~b_clr;
            rst = ($urandom_range(0, 299) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/dem_gpg_ctrl.md
Name: dem_gpg_ctrl

Overview:
- Control FSM that sequences the stopwatch/clock counter block. Turns debounced button levels into the counter's control strobes:
  - 100 Hz count enable `ena_db`
  - field select `gt_mod`
  - up/down levels and the 5 Hz set-step strobe `ena5hz`
  - a synchronous clear pulse
- Sits between the button debouncers and the counter. Also drives a blink enable for the display driver.

Parameters:
- DIV_100HZ, 500000, `ckht` cycles per `ena_db` tick (50 MHz / 100 Hz).
- HOLD_CYC, 25000000, cycles a held up/down button must stay pressed before auto-repeat starts (0.5 s).
- REP_CYC, 10000000, cycles between auto-repeat steps (5 Hz).
- BLINK_CYC, 12500000, cycles per half-period of `blink` (2 Hz toggle).

Ports:
- ckht  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- btn_ss  in  1  debounced start/stop level.
- btn_mode  in  1  debounced mode level.
- btn_up  in  1  debounced up level.
- btn_dw  in  1  debounced down level.
- btn_clr  in  1  debounced clear level.
- ena_db  out  1  1-cycle count tick, 100 Hz, only in RUN.
- gt_mod  out  2  00 none, 01 seconds, 10 minutes, 11 hours.
- ena_up  out  1  level, up step direction.
- ena_dw  out  1  level, down step direction.
- ena5hz  out  1  1-cycle set-step strobe.
- clr_cnt  out  1  1-cycle counter clear, ORed with rst at top level.
- running  out  1  high in RUN.
- blink  out  1  display blank gate; 1 = field visible.

Behaviour:
- Edge detection:
  - One register per button; `press_x = btn_x & ~btn_x_q`.
  - All outputs are registered. A press sampled at edge k affects outputs from edge k+1.
- States:
  - STOP: `gt_mod`=00.
  - RUN: `gt_mod`=00, `running`=1.
  - SET_S: `gt_mod`=01.
  - SET_M: `gt_mod`=10.
  - SET_H: `gt_mod`=11.
  - Reset state is STOP.
- Transitions:
  - STOP --press_ss--> RUN.
  - RUN --press_ss--> STOP.
  - STOP --press_mode--> SET_S --press_mode--> SET_M --press_mode--> SET_H --press_mode--> STOP.
  - press_mode in RUN is ignored. press_ss in SET_* is ignored.
  - press_ss and press_mode in the same cycle: press_ss wins in STOP/RUN; press_mode wins in SET_*.
- Prescaler (width `clog2(DIV_100HZ)`):
  - Counts only in RUN; frozen elsewhere.
  - On reaching DIV_100HZ-1 it wraps to 0 and `ena_db`=1 for that one cycle.
  - Cleared by rst and by `clr_cnt`.
- Clear:
  - press_clr in STOP gives `clr_cnt`=1 for exactly one cycle and zeroes the prescaler.
  - press_clr is ignored in RUN and SET_*.
- Direction levels:
  - In SET_*: `ena_up = btn_up & ~btn_dw`, `ena_dw = btn_dw & ~btn_up`.
  - Both 0 outside SET_*.
- Step strobe `ena5hz`:
  - Only in SET_*, and only while exactly one of up/dw is held.
  - First pulse: the cycle after the press edge.
  - Repeat counter `rcnt` then counts held cycles. Next pulse when `rcnt` = HOLD_CYC; after that, one pulse every REP_CYC cycles.
  - `rcnt` clears on release, on both buttons held, and on any state change.
  - After any of those clears, no further pulse until a new press edge.
  - The second button pressed while the first is held clears `rcnt`. It does not produce a pulse.
- Blink:
  - In SET_*, toggles every BLINK_CYC cycles; starts at 1 on entry to each SET state.
  - Forced to 1 while `ena5hz` repeat is active (held button), and in STOP/RUN.
- Reset values:
  - `ena_db`, `ena_up`, `ena_dw`, `ena5hz`, `clr_cnt`, `running` = 0.
  - `gt_mod` = 00; `blink` = 1.
  - All counters = 0; button history registers = 0.
- Reset mid-operation:
  - rst in any state returns to STOP next edge with reset output values.
  - Buttons held across rst release produce no press edge.

Test Plan:
- Test params: DIV_100HZ=4, HOLD_CYC=10, REP_CYC=3, BLINK_CYC=5. All tests start after rst.
- Start/stop: press_ss, wait 12 cycles, press_ss -> `running`=1 and `ena_db` pulses every 4th cycle (3 pulses); stop, then restart -> first tick continues from frozen prescaler phase.
- Mode cycle: 4 press_mode from STOP -> `gt_mod` 01,10,11,00; press_mode during RUN -> `gt_mod` stays 00.
- Hold up in SET_M for 20 cycles -> `ena_up`=1 throughout; `ena5hz` at cycles 1, 11, 14, 17, 20 after press; release -> no further pulses.
- Up and dw held together -> `ena_up`=`ena_dw`=0 and no `ena5hz`; release dw -> no pulse until up is re-pressed.
- press_clr in STOP -> single-cycle `clr_cnt`; press_clr in RUN -> none.
- rst asserted in SET_H with up held -> next edge STOP, `gt_mod`=00, `ena5hz`=0, no step after rst release.
